// File: rtl/lzrw1_decoder.sv
// lzrw1_decoder: streaming LZRW1 block decompressor.
//
// Reads the compressed stream from a first-word-fall-through FIFO and emits
// one plaintext byte per handshake. It parses 16-bit control words, literal
// bytes and 2-byte copy items. Copy items are resolved from a circular
// history buffer of the most recent output bytes.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   start_in            begins a block in IDLE/DONE, latches comp_len_in
//   comp_len_in         compressed block length in bytes (control words included)
//   fifo_data_in        FIFO head byte, valid while fifo_empty_in is low
//   fifo_empty_in       FIFO empty flag
//   fifo_rd_en_out      pops the FIFO head at this clock edge
//   data_out            decompressed byte
//   data_valid_out      data_out valid; a byte transfers when also out_ready_in
//   out_ready_in        downstream can accept a byte
//   busy_out            high while a block is being decoded
//   done_out            high in DONE until the next start_in
//   error_out           sticky malformed-stream flag, cleared by start_in
//   out_count_out       bytes emitted in the current block

module lzrw1_decoder #(
    parameter int unsigned HIST_SIZE = 4096,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_in,
    input  logic [CNT_WIDTH-1:0] comp_len_in,
    input  logic [7:0]           fifo_data_in,
    input  logic                 fifo_empty_in,
    output logic                 fifo_rd_en_out,
    output logic [7:0]           data_out,
    output logic                 data_valid_out,
    input  logic                 out_ready_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out,
    output logic [CNT_WIDTH-1:0] out_count_out
);

    localparam int unsigned AW = $clog2(HIST_SIZE);
    localparam int unsigned OW = 12;
    localparam int unsigned CW = (AW > OW) ? AW : OW;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]        PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE,
        S_CTRL0,
        S_CTRL1,
        S_ITEM,
        S_LIT,
        S_CPY0,
        S_CPY1,
        S_CRD,
        S_CWR,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] consumed;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 error_q;
    logic [15:0]          ctrl;
    logic [3:0]           bit_idx;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        written;
    logic [7:0]           b0_q;
    logic [OW-1:0]        offset_q;
    logic [4:0]           remaining;
    logic [7:0]           rd_data;

    logic [7:0] hist [HIST_SIZE];

    logic          at_end;
    logic          start_ok;
    logic          hist_we;
    logic [7:0]    hist_wdata;
    logic          set_err;
    logic          adv;
    logic [OW-1:0] cpy_offset;
    logic          offset_bad;
    logic [AW-1:0] rd_addr;
    state_t        adv_state;

    assign at_end     = (consumed == len_q);
    assign start_ok   = start_in && (state == S_IDLE || state == S_DONE);
    assign cpy_offset = {b0_q[7:4], fifo_data_in};
    // written saturates at HIST_SIZE-1, so this also rejects offsets that
    // would reach past the history depth.
    assign offset_bad = (cpy_offset == '0) || (CW'(cpy_offset) > CW'(written));
    assign rd_addr    = wr_ptr - AW'(offset_q);
    assign adv_state  = (bit_idx == 4'd15) ? S_CTRL0 : S_ITEM;
    // An item completes on its last output byte; the bit advance is folded
    // into that same cycle instead of using a separate state.
    assign adv        = hist_we && (state == S_LIT || remaining == 5'd1);

    assign busy_out      = !(state == S_IDLE || state == S_DONE);
    assign done_out      = (state == S_DONE);
    assign error_out     = error_q;
    assign out_count_out = out_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        fifo_rd_en_out = 1'b0;
        data_valid_out = 1'b0;
        data_out       = '0;
        hist_we        = 1'b0;
        hist_wdata     = rd_data;
        set_err        = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_in) state_next = S_CTRL0;
            end
            S_CTRL0: begin
                if (at_end) begin
                    state_next = S_DONE;
                end else if (!fifo_empty_in) begin
                    fifo_rd_en_out = 1'b1;
                    state_next     = S_CTRL1;
                end
            end
            S_CTRL1: begin
                if (at_end) begin
                    set_err    = 1'b1;
                    state_next = S_DONE;
                end else if (!fifo_empty_in) begin
                    fifo_rd_en_out = 1'b1;
                    state_next     = S_ITEM;
                end
            end
            S_ITEM: begin
                if (at_end) begin
                    state_next = S_DONE;
                end else if (ctrl[bit_idx]) begin
                    state_next = S_CPY0;
                end else begin
                    state_next = S_LIT;
                end
            end
            S_LIT: begin
                if (!fifo_empty_in && out_ready_in) begin
                    fifo_rd_en_out = 1'b1;
                    data_valid_out = 1'b1;
                    data_out       = fifo_data_in;
                    hist_we        = 1'b1;
                    hist_wdata     = fifo_data_in;
                    state_next     = adv_state;
                end
            end
            S_CPY0: begin
                if (at_end) begin
                    set_err    = 1'b1;
                    state_next = S_DONE;
                end else if (!fifo_empty_in) begin
                    fifo_rd_en_out = 1'b1;
                    state_next     = S_CPY1;
                end
            end
            S_CPY1: begin
                if (at_end) begin
                    set_err    = 1'b1;
                    state_next = S_DONE;
                end else if (!fifo_empty_in) begin
                    fifo_rd_en_out = 1'b1;
                    if (offset_bad) begin
                        set_err    = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_CRD;
                    end
                end
            end
            S_CRD: begin
                state_next = S_CWR;
            end
            S_CWR: begin
                data_valid_out = 1'b1;
                data_out       = rd_data;
                if (out_ready_in) begin
                    hist_we    = 1'b1;
                    state_next = (remaining == 5'd1) ? adv_state : S_CRD;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q     <= '0;
            consumed  <= '0;
            out_count <= '0;
            error_q   <= 1'b0;
            ctrl      <= '0;
            bit_idx   <= '0;
            wr_ptr    <= '0;
            written   <= '0;
            b0_q      <= '0;
            offset_q  <= '0;
            remaining <= '0;
        end else begin
            if (start_ok) begin
                len_q     <= comp_len_in;
                consumed  <= '0;
                out_count <= '0;
                error_q   <= 1'b0;
                wr_ptr    <= '0;
                written   <= '0;
            end
            if (fifo_rd_en_out) consumed <= consumed + CNT_ONE;
            if (set_err) error_q <= 1'b1;
            if (fifo_rd_en_out) begin
                case (state)
                    S_CTRL0: ctrl[7:0] <= fifo_data_in;
                    S_CTRL1: begin
                        ctrl[15:8] <= fifo_data_in;
                        bit_idx    <= '0;
                    end
                    S_CPY0: b0_q <= fifo_data_in;
                    S_CPY1: begin
                        offset_q  <= cpy_offset;
                        remaining <= {1'b0, b0_q[3:0]} + 5'd3;
                    end
                    default: ;
                endcase
            end
            if (hist_we) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                out_count <= out_count + CNT_ONE;
                if (written != '1) written <= written + PTR_ONE;
                if (state == S_CWR) remaining <= remaining - 5'd1;
            end
            if (adv) bit_idx <= bit_idx + 4'd1;
        end
    end

    // History storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (hist_we) hist[wr_ptr] <= hist_wdata;
        if (state == S_CRD) rd_data <= hist[rd_addr];
    end

endmodule

// File: tb/tb_lzrw1_decoder.sv
// tb_lzrw1_decoder: self-checking bench for lzrw1_decoder.
// A behavioural LZRW1 parser computes the expected byte stream, error flag
// and count for each block; a monitor compares every transferred byte.

module tb_lzrw1_decoder;

    localparam int unsigned HS = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_in = 1'b0;
    logic [CW-1:0] comp_len_in = '0;
    logic [7:0]    fifo_data_in = '0;
    logic          fifo_empty_in = 1'b1;
    logic          fifo_rd_en_out;
    logic [7:0]    data_out;
    logic          data_valid_out;
    logic          out_ready_in = 1'b0;
    logic          busy_out;
    logic          done_out;
    logic          error_out;
    logic [CW-1:0] out_count_out;

    lzrw1_decoder #(.HIST_SIZE(HS), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_in       (start_in),
        .comp_len_in    (comp_len_in),
        .fifo_data_in   (fifo_data_in),
        .fifo_empty_in  (fifo_empty_in),
        .fifo_rd_en_out (fifo_rd_en_out),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .out_ready_in   (out_ready_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out),
        .out_count_out  (out_count_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  stim_q[$];
    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  model_out[$];
    bit          model_err;
    bit          exp_err;
    int          exp_n;
    bit          mon_en = 1'b0;
    bit          pop_req = 1'b0;
    int unsigned rdy_mode = 0;
    int unsigned gap_pct = 0;
    int          xfer_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decoder over stim_q[0 .. len-1]; history limited to HS-1 bytes back.
    task automatic run_model(input int len);
        int pos = 0;
        int n;
        int off;
        int ln;
        bit stop = 1'b0;
        logic [15:0] ctrl;
        logic [7:0]  b0;
        logic [7:0]  b1;
        model_out.delete();
        model_err = 1'b0;
        while (!stop) begin
            if (pos >= len) break;
            ctrl[7:0] = stim_q[pos]; pos++;
            if (pos >= len) begin model_err = 1'b1; break; end
            ctrl[15:8] = stim_q[pos]; pos++;
            for (int b = 0; b < 16; b++) begin
                if (pos >= len) begin stop = 1'b1; break; end
                if (!ctrl[b]) begin
                    model_out.push_back(stim_q[pos]); pos++;
                end else begin
                    b0 = stim_q[pos]; pos++;
                    if (pos >= len) begin model_err = 1'b1; stop = 1'b1; break; end
                    b1 = stim_q[pos]; pos++;
                    off = int'({b0[7:4], b1});
                    ln  = int'(b0[3:0]) + 3;
                    n   = model_out.size();
                    if (n > int'(HS) - 1) n = int'(HS) - 1;
                    if (off == 0 || off > n) begin model_err = 1'b1; stop = 1'b1; break; end
                    for (int k = 0; k < ln; k++)
                        model_out.push_back(model_out[model_out.size() - off]);
                end
            end
        end
    endtask

    // Compare process: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pop_when_empty", 32'(fifo_rd_en_out & fifo_empty_in), 32'd0);
            if (prev_stall) begin
                chk("stall_valid", 32'(data_valid_out), 32'd1);
                chk("stall_data", 32'(data_out), 32'(prev_data));
            end
            if (data_valid_out && out_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %02h, expected no further output", data_out);
                end else begin
                    chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
                end
                xfer_cnt++;
            end
            prev_stall = data_valid_out && !out_ready_in;
            prev_data  = data_out;
        end else begin
            prev_stall = 1'b0;
        end
        pop_req = fifo_rd_en_out;
    end

    // FIFO and sink driver.
    always @(posedge clk) begin
        #1;
        if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_req = 1'b0;
        fifo_empty_in = (fifo_q.size() == 0) || ($urandom_range(0, 99) < gap_pct);
        fifo_data_in  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        case (rdy_mode)
            0: out_ready_in = 1'b1;
            1: out_ready_in = 1'($urandom_range(0, 1));
            2: out_ready_in = (xfer_cnt < 1);
            default: out_ready_in = ~out_ready_in;
        endcase
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en_out), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'd0);
        chk({tag, "_valid"}, 32'(data_valid_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy_out), 32'd0);
        chk({tag, "_done"}, 32'(done_out), 32'd0);
        chk({tag, "_error"}, 32'(error_out), 32'd0);
        chk({tag, "_count"}, 32'(out_count_out), 32'd0);
    endtask

    task automatic start_block(input int len, input int unsigned mode, input int unsigned gaps);
        run_model(len);
        exp_q    = model_out;
        exp_err  = model_err;
        exp_n    = model_out.size();
        fifo_q   = stim_q;
        rdy_mode = mode;
        gap_pct  = gaps;
        xfer_cnt = 0;
        mon_en   = 1'b1;
        @(posedge clk); #2;
        comp_len_in = CW'(len);
        start_in    = 1'b1;
        @(posedge clk); #2;
        start_in = 1'b0;
    endtask

    task automatic finish_block(input bit inject);
        int cyc = 0;
        while (!done_out && cyc < 10000) begin
            @(posedge clk); #2;
            cyc++;
            start_in = inject && (cyc == 6) && busy_out;
            if (start_in) comp_len_in = CW'(3);
        end
        start_in = 1'b0;
        if (!done_out) begin
            checks++;
            errors++;
            $display("FAIL timeout: done_out still 0 after %0d cycles", cyc);
            mon_en  = 1'b0;
            reset_n = 1'b0;
            #2 reset_n = 1'b1;
        end else begin
            chk("missing_bytes", 32'(exp_q.size()), 32'd0);
            chk("error_out", 32'(error_out), 32'(exp_err));
            chk("out_count", 32'(out_count_out), 32'(exp_n % 65536));
            chk("busy_in_done", 32'(busy_out), 32'd0);
        end
        repeat (3) @(posedge clk);
        #2 mon_en = 1'b0;
    endtask

    task automatic run_block(input int len, input int unsigned mode, input int unsigned gaps, input bit inject);
        start_block(len, mode, gaps);
        finish_block(inject);
    endtask

    task automatic gen_random(output int len);
        int gn = 0;
        int groups;
        int items;
        logic [15:0] ctrl;
        logic [3:0]  lnib;
        logic [11:0] off;
        stim_q.delete();
        groups = int'($urandom_range(1, 3));
        for (int g = 0; g < groups; g++) begin
            ctrl = 16'($urandom());
            stim_q.push_back(ctrl[7:0]);
            stim_q.push_back(ctrl[15:8]);
            items = (g == groups - 1) ? int'($urandom_range(1, 16)) : 16;
            for (int i = 0; i < items; i++) begin
                if (!ctrl[i]) begin
                    stim_q.push_back(8'($urandom()));
                    gn++;
                end else begin
                    lnib = 4'($urandom_range(0, 15));
                    if (gn == 0 || $urandom_range(0, 9) == 0)
                        off = 12'($urandom_range(0, 4095));
                    else
                        off = 12'($urandom_range(1, (gn > 15) ? 15 : gn));
                    stim_q.push_back({off[11:8], lnib});
                    stim_q.push_back(off[7:0]);
                    gn += int'(lnib) + 3;
                end
            end
        end
        len = stim_q.size();
        if (len > 2 && $urandom_range(0, 7) == 0) len -= int'($urandom_range(1, 2));
    endtask

    initial begin
        int rlen;
        int unsigned m;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        #2 chk_reset_outputs("reset");
        reset_n = 1'b1;

        // Literal expectations that pin the reference model itself
        stim_q = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43};
        run_model(5);
        chk("model_t1_len", 32'(model_out.size()), 32'd3);
        chk("model_t1_last", 32'(model_out[2]), 32'h43);
        stim_q = '{8'h02, 8'h00, 8'h41, 8'h00, 8'h01};
        run_model(5);
        chk("model_t2_len", 32'(model_out.size()), 32'd4);
        chk("model_t2_last", 32'(model_out[3]), 32'h41);

        // Literals
        stim_q = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43};
        run_block(5, 0, 0, 1'b0);
        chk("t1_count", 32'(out_count_out), 32'd3);
        chk("t1_done", 32'(done_out), 32'd1);

        // Overlapping run (offset 1, length 3)
        stim_q = '{8'h02, 8'h00, 8'h41, 8'h00, 8'h01};
        run_block(5, 0, 0, 1'b0);
        chk("t2_count", 32'(out_count_out), 32'd4);
        chk("t2_error", 32'(error_out), 32'd0);

        // Offset beyond written history, then offset 0
        stim_q = '{8'h02, 8'h00, 8'h41, 8'h10, 8'h01};
        run_block(5, 0, 0, 1'b0);
        chk("t3a_error", 32'(error_out), 32'd1);
        chk("t3a_count", 32'(out_count_out), 32'd1);
        stim_q = '{8'h01, 8'h00, 8'h00, 8'h00};
        run_block(4, 0, 0, 1'b0);
        chk("t3b_error", 32'(error_out), 32'd1);
        chk("t3b_count", 32'(out_count_out), 32'd0);

        // Toggling ready, FIFO gaps, and a start_in while busy
        stim_q = '{8'h02, 8'h00, 8'h41, 8'h00, 8'h01};
        run_block(5, 3, 40, 1'b1);
        chk("t4_count", 32'(out_count_out), 32'd4);

        // Control-word rollover; copy crosses the history wrap point
        stim_q = '{8'h00, 8'h00};
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(8'h10 + i));
        stim_q.push_back(8'h01); stim_q.push_back(8'h00);
        stim_q.push_back(8'h00); stim_q.push_back(8'h03);
        run_model(22);
        chk("model_t5_b16", 32'(model_out[16]), 32'h1D);
        run_block(22, 1, 20, 1'b0);
        chk("t5_count", 32'(out_count_out), 32'd19);

        // Truncated copy item
        stim_q = '{8'h02, 8'h00, 8'h41, 8'h00};
        run_block(4, 0, 0, 1'b0);
        chk("t6_error", 32'(error_out), 32'd1);
        chk("t6_count", 32'(out_count_out), 32'd1);

        // Reset while a copy byte is held by backpressure
        stim_q = '{8'h02, 8'h00, 8'h41, 8'h00, 8'h01};
        start_block(5, 2, 0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = data_valid_out && (xfer_cnt >= 1);
        end
        chk("t6_stall_reached", 32'(seen), 32'd1);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        stim_q = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43};
        run_block(5, 0, 0, 1'b0);
        chk("t6_after_reset_count", 32'(out_count_out), 32'd3);

        // Randomized blocks
        for (int t = 0; t < 40; t++) begin
            gen_random(rlen);
            m = $urandom_range(0, 2);
            if (m == 2) m = 3;
            run_block(rlen, m, $urandom_range(0, 30), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzrw1_decoder.md
Name: lzrw1_decoder

Overview:
- Consumes the compressed byte stream from the decompressor input FIFO and emits reconstructed plaintext bytes one at a time.
- Parses LZRW1 items: 16-bit control words, literal bytes, and 2-byte copy items.
- Keeps a circular history buffer so copy items can be resolved.
- Sits directly downstream of the decompressor FIFO and upstream of the output sink.

Parameters:
HIST_SIZE, 4096, history buffer depth in bytes (power of 2; max copy offset = HIST_SIZE-1).
CNT_WIDTH, 16, width of compressed-length input and output byte counter.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start_in  input  1  one-cycle pulse in IDLE/DONE; begins a block, latches comp_len_in
comp_len_in  input  CNT_WIDTH  compressed block length in bytes (control words included)
fifo_data_in  input  8  FIFO head byte, first-word-fall-through (valid while fifo_empty_in=0)
fifo_empty_in  input  1  FIFO empty flag
fifo_rd_en_out  output  1  pops FIFO head at this clock edge
data_out  output  8  decompressed byte
data_valid_out  output  1  data_out valid; byte transfers when data_valid_out & out_ready_in
out_ready_in  input  1  downstream can accept a byte
busy_out  output  1  high in every state except IDLE/DONE
done_out  output  1  high in DONE until next start_in
error_out  output  1  sticky malformed-stream flag, cleared by start_in
out_count_out  output  CNT_WIDTH  bytes emitted in current block

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0; counters, control word, bit index and history write pointer cleared.
  - History contents not cleared.
  - Reset mid-copy abandons the item immediately; no partial output after release.
- Format:
  - Control word is little-endian: first byte = bits[7:0].
  - Bits are consumed LSB first; bit=0 means literal, bit=1 means copy.
  - Copy bytes b0,b1: length = b0[3:0]+3 (3..18); offset = {b0[7:4],b1} (12 bits).
- Pop rule:
  - fifo_rd_en_out = state needs a byte & !fifo_empty_in (& out_ready_in in LIT).
  - Never asserted when empty.
  - consumed counter +1 per pop.
- States:
  - IDLE/DONE: on start_in latch len, clear consumed/out_count/error/wr_ptr/written -> CTRL0.
  - CTRL0: if consumed==len -> DONE; else pop -> ctrl[7:0] -> CTRL1.
  - CTRL1: if consumed==len -> error, DONE; else pop -> ctrl[15:8], bit_idx=0 -> ITEM.
  - ITEM: if consumed==len -> DONE (unused control bits ignored); ctrl[bit_idx]=0 -> LIT, else -> CPY0.
  - LIT: when byte available & out_ready_in: pop, data_out=byte, data_valid_out=1, write hist[wr_ptr], wr_ptr++, out_count++ -> ADV.
  - CPY0: if consumed==len -> error, DONE; else pop b0 -> CPY1.
  - CPY1: if consumed==len -> error, DONE; else pop b1.
    - offset==0 or offset>written -> error, DONE (written saturates at HIST_SIZE-1).
    - Otherwise remaining=length -> CRD.
  - CRD: synchronous read of hist[(wr_ptr-offset) mod HIST_SIZE] -> CWR.
  - CWR: present read byte with data_valid_out=1; hold until out_ready_in.
    - On transfer: write hist[wr_ptr], wr_ptr++, out_count++, remaining--.
    - remaining==0 -> ADV, else -> CRD.
    - Throughput is 1 byte / 2 cycles, so overlapping copies (offset<length, e.g. offset 1 run) are correct.
  - ADV (same-cycle decision, no extra state required): bit_idx==15 -> CTRL0, else bit_idx++ -> ITEM.
- data_valid_out asserted only in LIT (same cycle as pop) and CWR. data_out holds while stalled.
- wr_ptr wraps modulo HIST_SIZE. out_count wraps modulo 2^CNT_WIDTH.
- start_in while busy is ignored.
- DONE lasts until start_in.

Test Plan:
1. Literals: len=5, bytes 00 00 41 42 43, ready=1 -> out 41,42,43; done_out=1, out_count=3, error=0.
2. Overlap run: len=5, bytes 02 00 41 00 01 -> out 41,41,41,41; out_count=4, no error.
3. Bad offset: bytes 02 00 41 10 01 (offset 257 > written 1), len=5 -> out 41 only; error_out=1, done_out=1. Also bytes 01 00 00 00, len=4 -> offset 0 -> error, no output.
4. Backpressure/empty: scenario 2 with out_ready_in toggling every cycle and FIFO empty gaps -> identical byte sequence; no pop while empty; data_out stable while valid&!ready.
5. Control-word rollover: 16 literals then new control word 01 00 + copy 00 03 -> 16 literals, then 3 bytes copied from offset 3; out_count=19.
6. Truncation and reset: len=4, bytes 02 00 41 00 -> error after literal. Separately, assert reset_n=0 mid-CWR -> all outputs 0, IDLE; a fresh start_in decodes correctly.
